// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between the WB pipeline and a small MCU result FIFO.
// The pipeline normally wins; a starvation counter forces a FIFO grant and stalls WB for one cycle.
module regfile_wr_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        mcu_valid,
  input  logic [4:0]  mcu_waddr,
  input  logic [31:0] mcu_wdata,
  output logic        mcu_ready,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_WAIT + 1);

  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic empty, full, force_mcu, pop, push_store;
  logic [31:0] pend;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign force_mcu = !empty && (starve_cnt == SW'(MAX_WAIT));

  // All outputs are forced quiet while reset is high, even if the FIFO still holds entries.
  always_comb begin
    reg_wr     = 1'b0;
    waddr      = '0;
    wdata      = '0;
    pipe_stall = 1'b0;
    mcu_ready  = 1'b0;
    pop        = 1'b0;
    pend       = '0;
    if (!reset) begin
      mcu_ready  = !full;
      pipe_stall = force_mcu && pipe_valid;
      if (pipe_valid && !force_mcu) begin
        reg_wr = (pipe_waddr != 5'd0);
        waddr  = pipe_waddr;
        wdata  = pipe_wdata;
      end else if (!empty) begin
        reg_wr = 1'b1;
        waddr  = q_addr[rd_ptr];
        wdata  = q_data[rd_ptr];
        pop    = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i]) pend = pend | (32'd1 << q_addr[i]);
      end
    end
    pend_mask = {pend[31:1], 1'b0};
  end

  // Writes to x0 complete the handshake but are dropped rather than queued.
  assign push_store = mcu_valid && mcu_ready && (mcu_waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      q_vld      <= '0;
    end else begin
      if (push_store) wr_ptr <= wr_ptr + PW'(1);
      if (pop)        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_store) - CW'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && (PW'(i) == rd_ptr))             q_vld[i] <= 1'b0;
        else if (push_store && (PW'(i) == wr_ptr)) q_vld[i] <= 1'b1;
      end
      if (pop || empty)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(MAX_WAIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) begin
      q_addr[wr_ptr] <= mcu_waddr;
      q_data[wr_ptr] <= mcu_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector bench for regfile_wr_arbiter: a vector table plus hand-written multi-cycle sequences.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, mcu_valid;
  logic [4:0]  pipe_waddr, mcu_waddr;
  logic [31:0] pipe_wdata, mcu_wdata;
  logic        pipe_stall, mcu_ready, reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata, pend_mask;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wr_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
    .mcu_valid(mcu_valid), .mcu_waddr(mcu_waddr), .mcu_wdata(mcu_wdata), .mcu_ready(mcu_ready),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_wr;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_stall;
    logic        e_rdy;
    logic [31:0] e_pend;
  } vec_t;

  function automatic vec_t mk(string name, logic pv, logic [4:0] pa, logic [31:0] pd,
                              logic mv, logic [4:0] ma, logic [31:0] md,
                              logic e_wr, logic [4:0] e_wa, logic [31:0] e_wd,
                              logic e_stall, logic e_rdy, logic [31:0] e_pend);
    vec_t v;
    v.name = name; v.pv = pv; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
    v.e_wr = e_wr; v.e_wa = e_wa; v.e_wd = e_wd; v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_pend = e_pend;
    return v;
  endfunction

  function automatic logic [31:0] b(int i);
    return 32'd1 << i;
  endfunction

  function automatic logic [31:0] dd(int n);
    return 32'hD000_0000 + 32'(n);
  endfunction

  function automatic logic [31:0] cc(int n);
    return 32'hC000_0000 + 32'(n);
  endfunction

  task automatic chk(string name, string field, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h expected %h", name, field, act, exp);
    end
  endtask

  // Called one time unit after a posedge: drive, settle, check, advance to next cycle.
  task automatic run_vec(vec_t v);
    pipe_valid = v.pv; pipe_waddr = v.pa; pipe_wdata = v.pd;
    mcu_valid  = v.mv; mcu_waddr  = v.ma; mcu_wdata  = v.md;
    #3;
    chk(v.name, "reg_wr",     32'(reg_wr),     32'(v.e_wr));
    chk(v.name, "waddr",      32'(waddr),      32'(v.e_wa));
    chk(v.name, "wdata",      wdata,           v.e_wd);
    chk(v.name, "pipe_stall", 32'(pipe_stall), 32'(v.e_stall));
    chk(v.name, "mcu_ready",  32'(mcu_ready),  32'(v.e_rdy));
    chk(v.name, "pend_mask",  pend_mask,       v.e_pend);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk("t2_push5",   0, 0, 0,            1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 1, 0);
    tbl[1]  = mk("t2_wr5",     0, 0, 0,            0, 0, 0,            1, 5, 32'hDEADBEEF, 0, 1, b(5));
    tbl[2]  = mk("t2_idle",    0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 1, 0);
    tbl[3]  = mk("t5_push0",   0, 0, 0,            1, 0, 32'h1234,     0, 0, 0,            0, 1, 0);
    tbl[4]  = mk("t5_after0",  0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 1, 0);
    tbl[5]  = mk("t5_pipe_x0", 1, 0, 32'hAAAA,     0, 0, 0,            0, 0, 32'hAAAA,     0, 1, 0);
    tbl[6]  = mk("pipe_x3",    1, 3, 32'h33,       0, 0, 0,            1, 3, 32'h33,       0, 1, 0);
    tbl[7]  = mk("t3_push7",   1, 1, 32'h11,       1, 7, 32'h77,       1, 1, 32'h11,       0, 1, 0);
    tbl[8]  = mk("t3_deny1",   1, 2, 32'h22,       0, 0, 0,            1, 2, 32'h22,       0, 1, b(7));
    tbl[9]  = mk("t3_deny2",   1, 2, 32'h23,       0, 0, 0,            1, 2, 32'h23,       0, 1, b(7));
    tbl[10] = mk("t3_deny3",   1, 6, 32'h66,       0, 0, 0,            1, 6, 32'h66,       0, 1, b(7));
    tbl[11] = mk("t3_force",   1, 4, 32'h44,       0, 0, 0,            1, 7, 32'h77,       1, 1, b(7));
    tbl[12] = mk("t3_replay",  1, 4, 32'h44,       0, 0, 0,            1, 4, 32'h44,       0, 1, 0);

    reset = 1'b1;
    pipe_valid = 0; pipe_waddr = 0; pipe_wdata = 0;
    mcu_valid = 0; mcu_waddr = 0; mcu_wdata = 0;
    @(posedge clk); @(posedge clk); #1;
    run_vec(mk("rst_hold", 1, 3, 32'h5, 1, 4, 32'h6, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Fill to full under a busy pipe; a push offered while full is refused even with a forced pop.
    for (int n = 0; n < 4; n++) begin
      logic [31:0] p;
      p = 0;
      for (int k = 0; k < n; k++) p = p | b(10 + k);
      run_vec(mk("t4_fill", 1, 9, 32'h99, 1, 5'(10 + n), dd(10 + n), 1, 9, 32'h99, 0, 1, p));
    end
    run_vec(mk("t4_full_force", 1, 9, 32'h99, 1, 14, dd(14), 1, 10, dd(10), 1, 0, b(10)|b(11)|b(12)|b(13)));
    run_vec(mk("t4_retry",      1, 9, 32'h99, 1, 14, dd(14), 1, 9,  32'h99, 0, 1, b(11)|b(12)|b(13)));
    run_vec(mk("t4_drain11",    0, 0, 0,      0, 0,  0,      1, 11, dd(11), 0, 0, b(11)|b(12)|b(13)|b(14)));
    run_vec(mk("t4_drain12",    0, 0, 0,      0, 0,  0,      1, 12, dd(12), 0, 1, b(12)|b(13)|b(14)));
    run_vec(mk("t4_drain13",    0, 0, 0,      0, 0,  0,      1, 13, dd(13), 0, 1, b(13)|b(14)));
    run_vec(mk("t4_drain14",    0, 0, 0,      0, 0,  0,      1, 14, dd(14), 0, 1, b(14)));
    run_vec(mk("t4_empty",      0, 0, 0,      0, 0,  0,      0, 0,  0,      0, 1, 0));

    // Build count=2, then stream push+pop across the pointer wrap.
    run_vec(mk("t6_push20", 1, 9, 32'h99, 1, 20, cc(20), 1, 9, 32'h99, 0, 1, 0));
    run_vec(mk("t6_push21", 1, 9, 32'h99, 1, 21, cc(21), 1, 9, 32'h99, 0, 1, b(20)));
    for (int n = 0; n < 4; n++)
      run_vec(mk("t6_pushpop", 0, 0, 0, 1, 5'(22 + n), cc(22 + n), 1, 5'(20 + n), cc(20 + n), 0, 1,
                 b(20 + n) | b(21 + n)));
    run_vec(mk("t6_pop24", 0, 0, 0, 0, 0, 0, 1, 24, cc(24), 0, 1, b(24)|b(25)));
    run_vec(mk("t6_pop25", 0, 0, 0, 0, 0, 0, 1, 25, cc(25), 0, 1, b(25)));
    run_vec(mk("t6_empty", 0, 0, 0, 0, 0, 0, 0, 0,  0,      0, 1, 0));

    // Reset with three queued entries: everything is dropped.
    run_vec(mk("t1_q1", 1, 9, 32'h99, 1, 1, dd(1), 1, 9, 32'h99, 0, 1, 0));
    run_vec(mk("t1_q2", 1, 9, 32'h99, 1, 2, dd(2), 1, 9, 32'h99, 0, 1, b(1)));
    run_vec(mk("t1_q3", 1, 9, 32'h99, 1, 3, dd(3), 1, 9, 32'h99, 0, 1, b(1)|b(2)));
    reset = 1'b1;
    run_vec(mk("t1_in_reset", 1, 9, 32'h99, 1, 4, dd(4), 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    run_vec(mk("t1_post1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    run_vec(mk("t1_post2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
